// File: rtl/rr_arbiter_quantum.sv
// Round-robin arbiter with a per-ownership quantum and a per-requester lock override.
// Latency: 1 cycle from request (while idle) to registered grant; all outputs are registered.
// Backpressure: none. Requesters hold req until granted; lock[owner] extends ownership past the quantum.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   req         level-sensitive request lines, one per requester
//   lock        lock[i] keeps ownership past the quantum while i owns the grant
//   grant       registered one-hot grant, all-zero when idle
//   grant_valid OR of grant
//   grant_idx   encoded owner index, holds its last value while idle
//   handover    one-cycle pulse in the first cycle of a grant to a new owner
module rr_arbiter_quantum #(
  parameter int NUM_REQ = 4,
  parameter int QUANTUM = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(QUANTUM + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               handover
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_OWN  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);

  logic [0:0]         state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               handover_nxt;
  logic [IDX_W-1:0]   pick_ptr;
  logic [IDX_W-1:0]   pick_after;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  // First set bit of mask scanning upward from start, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] pick(input logic [IDX_W-1:0] start,
                                            input logic [NUM_REQ-1:0] mask);
    logic [IDX_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && mask[idx]) begin
        found = 1'b1;
        res   = idx[IDX_W-1:0];
      end
    end
    return res;
  endfunction

  assign pick_ptr   = pick(ptr, req);
  // Scanning from owner+1 puts the current owner last, so it only wins
  // again when it is the sole requester.
  assign pick_after = pick(inc_idx(grant_idx), req);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    idx_nxt      = grant_idx;
    grant_nxt    = grant;
    handover_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt    = ST_OWN;
          idx_nxt      = pick_ptr;
          grant_nxt    = NUM_REQ'(1) << pick_ptr;
          cnt_nxt      = CNT_ONE;
          handover_nxt = 1'b1;
          ptr_nxt      = inc_idx(pick_ptr);
        end
      end
      ST_OWN: begin
        if (!req[grant_idx]) begin
          if (|req) begin
            idx_nxt      = pick_after;
            grant_nxt    = NUM_REQ'(1) << pick_after;
            cnt_nxt      = CNT_ONE;
            handover_nxt = 1'b1;
            ptr_nxt      = inc_idx(pick_after);
          end else begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            cnt_nxt   = '0;
          end
        end else if (lock[grant_idx]) begin
          // Locked owner keeps counting but saturates, so a later unlock
          // expires immediately.
          if (cnt < CNT_MAX) cnt_nxt = cnt + CNT_ONE;
        end else if (cnt < CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          // Quantum expired; a sole requester is re-granted without a gap.
          idx_nxt      = pick_after;
          grant_nxt    = NUM_REQ'(1) << pick_after;
          cnt_nxt      = CNT_ONE;
          handover_nxt = (pick_after != grant_idx);
          ptr_nxt      = inc_idx(pick_after);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      handover  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      handover  <= handover_nxt;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter_quantum.sv
// Testbench for rr_arbiter_quantum: directed scenarios plus randomized traffic.
// Latency: compares registered outputs 1 time unit after every rising edge.
// Backpressure: not applicable; inputs are driven freely each cycle.
module tb_rr_arbiter_quantum;

  localparam int NR = 4;
  localparam int Q  = 4;
  localparam int IW = $clog2(NR);

  logic          clk;
  logic          reset_n;
  logic [NR-1:0] req;
  logic [NR-1:0] lock;
  logic [NR-1:0] grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          handover;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, for how many cycles, and where
  // the next search from idle begins.
  bit m_busy;
  int m_owner;
  int m_held;
  int m_start;
  bit m_ho;

  rr_arbiter_quantum #(.NUM_REQ(NR), .QUANTUM(Q)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .handover    (handover)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(int start, logic [NR-1:0] mask);
    for (int k = 0; k < NR; k++) begin
      if (mask[(start + k) % NR]) return (start + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_new_owner(input int who, input bit pulse);
    m_owner = who;
    m_held  = 1;
    m_ho    = pulse;
    m_start = (who + 1) % NR;
  endtask

  task automatic model_cycle(input logic [NR-1:0] r, input logic [NR-1:0] l);
    m_ho = 1'b0;
    if (!m_busy) begin
      if (r != 0) begin
        m_busy = 1'b1;
        model_new_owner(first_from(m_start, r), 1'b1);
      end
    end else if (!r[m_owner]) begin
      if (r != 0) model_new_owner(first_from(m_owner + 1, r), 1'b1);
      else m_busy = 1'b0;
    end else if (l[m_owner]) begin
      m_held = (m_held + 1 > Q) ? Q : m_held + 1;
    end else if (m_held < Q) begin
      m_held++;
    end else begin
      int nxt;
      nxt = first_from(m_owner + 1, r);
      model_new_owner(nxt, nxt != m_owner);
    end
  endtask

  task automatic compare_model();
    logic [31:0] eg;
    eg = m_busy ? (32'd1 << m_owner) : 32'd0;
    chk("grant", 32'(grant), eg);
    chk("grant_valid", 32'(grant_valid), 32'(m_busy));
    chk("grant_idx", 32'(grant_idx), 32'(m_owner));
    chk("handover", 32'(handover), 32'(m_ho));
  endtask

  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l);
    req  = r;
    lock = l;
    model_cycle(r, l);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset(input logic [NR-1:0] r);
    reset_n = 1'b0;
    req     = r;
    lock    = '0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_held  = 0;
    m_start = 0;
    m_ho    = 1'b0;
    @(posedge clk);
    #1;
    compare_model();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] rr;
    logic [NR-1:0] ll;
    reset_n = 1'b0;
    req     = '0;
    lock    = '0;

    // Reset and idle behaviour, then a grant dropped by reset.
    do_reset(4'b0000);
    do_reset(4'b0000);
    chk("rst_grant", 32'(grant), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, 4'b0000);
      chk("idle_valid", 32'(grant_valid), 32'd0);
    end
    step(4'b1111, 4'b0000);
    chk("pre_rst_grant", 32'(grant), 32'b0001);
    do_reset(4'b1111);
    chk("mid_rst_grant", 32'(grant), 32'd0);

    // All requesting: four cycles each in strict rotation.
    for (int k = 1; k <= 20; k++) begin
      step(4'b1111, 4'b0000);
      chk("rot_idx", 32'(grant_idx), 32'(((k - 1) / 4) % 4));
      chk("rot_ho", 32'(handover), 32'(((k - 1) % 4) == 0));
    end
    step(4'b0000, 4'b0000);

    // Sole requester is re-granted across expiry with no gap.
    for (int k = 1; k <= 10; k++) begin
      step(4'b0100, 4'b0000);
      chk("sole_grant", 32'(grant), 32'b0100);
      chk("sole_ho", 32'(handover), 32'(k == 1));
    end
    step(4'b0000, 4'b0000);

    // Owner 1 releases early while requester 3 waits.
    step(4'b0010, 4'b0000);
    chk("rel_grant1", 32'(grant), 32'b0010);
    step(4'b0010, 4'b0000);
    step(4'b1000, 4'b0000);
    chk("rel_grant3", 32'(grant), 32'b1000);
    chk("rel_ho", 32'(handover), 32'd1);
    step(4'b0000, 4'b0000);
    chk("rel_idle", 32'(grant), 32'd0);

    // Locked owner 0 holds past the quantum, then expires on unlock.
    for (int k = 0; k < 10; k++) begin
      step(4'b0011, 4'b0001);
      chk("lock_grant", 32'(grant), 32'b0001);
    end
    step(4'b0011, 4'b0000);
    chk("unlock_grant", 32'(grant), 32'b0010);
    chk("unlock_ho", 32'(handover), 32'd1);
    step(4'b0000, 4'b0000);

    // Wrap after owner 3, then expiry of owner 0 moves to 2.
    step(4'b1000, 4'b0000);
    chk("wrap_own3", 32'(grant), 32'b1000);
    step(4'b0101, 4'b0000);
    chk("wrap_own0", 32'(grant), 32'b0001);
    for (int k = 0; k < 3; k++) step(4'b0101, 4'b0000);
    chk("wrap_hold0", 32'(grant), 32'b0001);
    step(4'b0101, 4'b0000);
    chk("wrap_own2", 32'(grant), 32'b0100);

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(NR'($urandom));
      end else begin
        rr = NR'($urandom);
        ll = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
        step(rr, ll);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
